// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard unit
//
// Forward-select encodings, the shadow-slot record that mirrors a pipeline
// stage's destination information, and the producer / forward-select helpers.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] dest;
  } slot_t;

  localparam int    SLOT_W = $bits(slot_t);
  localparam slot_t BUBBLE = '0;

  // $0 is hard-wired to zero, so a write to it never produces a value.
  function automatic logic is_producer(slot_t s);
    return s.valid & s.regwrite & (s.dest != 5'd0);
  endfunction

  // The younger producer (currently in EX, about to be in MEM) wins.
  function automatic logic [1:0] fwd_sel(logic uses, logic [4:0] src,
                                         slot_t e, slot_t m);
    if (uses && is_producer(e) && (e.dest == src)) return FWD_MEM;
    if (uses && is_producer(m) && (m.dest == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Ports:
//   clk    pipeline clock
//   reset  asynchronous active-high reset, clears the count
//   en     count this cycle
//   count  current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, load-use stall and branch flush control
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   rs_D, rt_D, rd_D              ID-stage register fields
//   uses_rs_D, uses_rt_D          ID instruction reads rs / rt
//   valid_D                       ID slot holds a real instruction
//   regwrite_D, memtoreg_D        ID control bits
//   regdst_D                      1: dest = rd_D, 0: dest = rt_D
//   branch_taken_M                branch in MEM resolved taken
//   ForwardA, ForwardB            registered EX operand selects
//   StallF, StallD                hold PC and IF/ID
//   FlushD, FlushE                bubble IF/ID and ID/EX
//   stall_count, flush_count      saturating event counters
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [4:0]       rd_D,
  input  logic             uses_rs_D,
  input  logic             uses_rt_D,
  input  logic             valid_D,
  input  logic             regwrite_D,
  input  logic             memtoreg_D,
  input  logic             regdst_D,
  input  logic             branch_taken_M,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Only the E and M shadows are kept: a WB producer needs no forwarding
  // because the register file is write-through, so nothing reads a W copy.
  slot_t e_q;
  slot_t m_q;
  slot_t slot_d;
  logic  lu;
  logic  flush_e;

  always_comb begin
    slot_d          = BUBBLE;
    slot_d.valid    = valid_D;
    slot_d.regwrite = regwrite_D;
    slot_d.memtoreg = memtoreg_D;
    slot_d.dest     = regdst_D ? rd_D : rt_D;
  end

  assign lu = is_producer(e_q) & e_q.memtoreg & valid_D &
              ((uses_rs_D & (rs_D == e_q.dest)) |
               (uses_rt_D & (rt_D == e_q.dest)));

  assign flush_e = branch_taken_M | lu;

  // Branch flush overrides the stall; all controls are quiet during reset.
  assign FlushD = branch_taken_M & ~reset;
  assign FlushE = flush_e & ~reset;
  assign StallD = lu & ~branch_taken_M & ~reset;
  assign StallF = StallD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q      <= BUBBLE;
      m_q      <= BUBBLE;
      ForwardA <= FWD_RF;
      ForwardB <= FWD_RF;
    end else begin
      m_q <= branch_taken_M ? BUBBLE : e_q;
      if (flush_e) begin
        e_q      <= BUBBLE;
        ForwardA <= FWD_RF;
        ForwardB <= FWD_RF;
      end else begin
        // Selects look at the slots as they are before this edge: old E
        // becomes MEM, old M becomes WB during the new EX cycle.
        e_q      <= slot_d;
        ForwardA <= fwd_sel(uses_rs_D, rs_D, e_q, m_q);
        ForwardB <= fwd_sel(uses_rt_D, rt_D, e_q, m_q);
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (StallD),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (branch_taken_M),
    .count (flush_count)
  );

endmodule
